seq_divider: RTL and testbench

- Sequential signed restoring divider; the inverse datapath of the team's shift-add signed multiplier, with the same start/busy handshake.
- Recovers a quotient and remainder from a 16-bit signed product-width value and an 8-bit signed operand, e.g. membrane-potential and weight normalisation in the SNN datapath.
- Produces one quotient bit per clock. Latency is constant regardless of operand values.

---
 rtl/seq_divider.sv | 128 ++++++++++++
 tb/tb_seq_divider.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential signed restoring divider: one quotient bit per clock, constant latency.
// Start/busy/done handshake; saturates on MIN/-1 and flags divide-by-zero.
module seq_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic          dz
);

  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] QMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] QMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t        r_state;
  logic [DW-1:0] r_dvd;
  logic [VW-1:0] r_dvs;
  logic [VW:0]   r_prem;
  logic [CW-1:0] r_cnt;
  logic          r_sgn_dvd;
  logic          r_sgn_dvs;
  logic          r_dz;

  logic [DW:0]   w_dvd_sx;
  logic [DW:0]   w_dvd_abs;
  logic [VW:0]   w_dvs_sx;
  logic [VW:0]   w_dvs_abs;
  logic [VW:0]   w_shift;
  logic [VW+1:0] w_diff;
  logic          w_qneg;
  logic [DW:0]   w_qmag;
  logic [DW:0]   w_qsgn;

  // Magnitudes are one bit wider so the most negative operand is representable.
  assign w_dvd_sx  = {dividend[DW-1], dividend};
  assign w_dvd_abs = dividend[DW-1] ? (~w_dvd_sx + 1'b1) : w_dvd_sx;
  assign w_dvs_sx  = {divisor[VW-1], divisor};
  assign w_dvs_abs = divisor[VW-1] ? (~w_dvs_sx + 1'b1) : w_dvs_sx;

  // The dividend register doubles as the quotient register: its MSB feeds the
  // partial remainder while the new quotient bit enters at the LSB.
  assign w_shift = {r_prem[VW-1:0], r_dvd[DW-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_dvs};

  assign w_qneg = r_sgn_dvd ^ r_sgn_dvs;
  assign w_qmag = {1'b0, r_dvd};
  assign w_qsgn = w_qneg ? (~w_qmag + 1'b1) : w_qmag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_prem    <= '0;
      r_cnt     <= '0;
      r_sgn_dvd <= 1'b0;
      r_sgn_dvs <= 1'b0;
      r_dz      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd     <= DW'(w_dvd_abs);
            r_dvs     <= VW'(w_dvs_abs);
            r_sgn_dvd <= dividend[DW-1];
            r_sgn_dvs <= divisor[VW-1];
            r_dz      <= (divisor == '0);
            r_prem    <= '0;
            r_cnt     <= '0;
            busy      <= 1'b1;
            r_state   <= S_CALC;
          end
        end
        S_CALC: begin
          r_dvd  <= {r_dvd[DW-2:0], ~w_diff[VW+1]};
          r_prem <= w_diff[VW+1] ? w_shift : w_diff[VW:0];
          if (r_cnt == CW'(DW-1)) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (r_dz) begin
            quotient  <= r_sgn_dvd ? QMIN : QMAX;
            remainder <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b1;
          end else if (!w_qneg && r_dvd[DW-1]) begin
            // Only MIN / -1 yields a positive magnitude of 2^(DW-1).
            quotient  <= QMAX;
            remainder <= '0;
            ovf       <= 1'b1;
            dz        <= 1'b0;
          end else begin
            quotient  <= DW'(w_qsgn);
            remainder <= r_sgn_dvd ? VW'(~r_prem + 1'b1) : VW'(r_prem);
            ovf       <= 1'b0;
            dz        <= 1'b0;
          end
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed vectors push expectations, a
// monitor pops and compares on every done pulse.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        dz;

  typedef struct {
    logic signed [15:0] q;
    logic signed [7:0]  r;
    logic               o;
    logic               z;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  seq_divider #(.DW(16), .VW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .ovf(ovf), .dz(dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("quotient",  $signed(quotient),  e.q);
        chk("remainder", $signed(remainder), e.r);
        chk("ovf", {31'b0, ovf}, {31'b0, e.o});
        chk("dz",  {31'b0, dz},  {31'b0, e.z});
      end
    end
  end

  // Issue one operation and measure how long busy stays high before done.
  // With disturb set, a start pulse with new operands lands mid-operation.
  task automatic do_op(input logic signed [15:0] a, input logic signed [7:0] b,
                       input logic signed [15:0] eq, input logic signed [7:0] er,
                       input logic eo, input logic ez, input bit disturb);
    int n;
    int g;
    exp_q.push_back('{eq, er, eo, ez});
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    g = 0;
    while (!done && g < 60) begin
      if (busy) n++;
      if (disturb && n == 5) begin
        start    = 1'b1;
        dividend = 16'sd7;
        divisor  = 8'sd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      g++;
    end
    start = 1'b0;
    if (g >= 60) chk("done_timeout", g, 0);
    else         chk("busy_cycles", n, 17);
  endtask

  initial begin
    int t1;
    int t2;
    int g;
    int ndone;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_quotient", {16'b0, quotient}, 0);
    chk("rst_remainder", {24'b0, remainder}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_flags", {30'b0, ovf, dz}, 0);
    rst_n = 1'b1;

    do_op(16'sd85,     -8'sd17,  -16'sd5,     8'sd0,   1'b0, 1'b0, 1'b0);
    do_op(-16'sd100,   8'sd7,    -16'sd14,    -8'sd2,  1'b0, 1'b0, 1'b0);
    do_op(16'sd32767,  -8'sd128, -16'sd255,   8'sd127, 1'b0, 1'b0, 1'b0);
    do_op(-16'sd32768, -8'sd1,   16'sd32767,  8'sd0,   1'b1, 1'b0, 1'b0);
    do_op(-16'sd32768, 8'sd1,    -16'sd32768, 8'sd0,   1'b0, 1'b0, 1'b0);
    do_op(16'sd1000,   8'sd0,    16'sd32767,  8'sd0,   1'b0, 1'b1, 1'b0);
    do_op(-16'sd5,     8'sd0,    -16'sd32768, 8'sd0,   1'b0, 1'b1, 1'b0);
    do_op(-16'sd7,     8'sd2,    -16'sd3,     -8'sd1,  1'b0, 1'b0, 1'b0);
    do_op(16'sd100,    -8'sd128, 16'sd0,      8'sd100, 1'b0, 1'b0, 1'b0);
    do_op(-16'sd32768, 8'sd127,  -16'sd258,   -8'sd2,  1'b0, 1'b0, 1'b0);
    do_op(-16'sd32768, -8'sd128, 16'sd256,    8'sd0,   1'b0, 1'b0, 1'b0);
    do_op(16'sd0,      8'sd5,    16'sd0,      8'sd0,   1'b0, 1'b0, 1'b0);
    do_op(16'sd255,    8'sd5,    16'sd51,     8'sd0,   1'b0, 1'b0, 1'b1);

    // Start held high: the second operation is taken on the edge after done.
    exp_q.push_back('{16'sd51, 8'sd0, 1'b0, 1'b0});
    exp_q.push_back('{16'sd1,  8'sd0, 1'b0, 1'b0});
    @(negedge clk);
    dividend = 16'sd255;
    divisor  = 8'sd5;
    start    = 1'b1;
    @(negedge clk);
    dividend = 16'sd7;
    divisor  = 8'sd7;
    g = 0;
    while (!done && g < 60) begin @(negedge clk); g++; end
    t1 = cyc;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!done && g < 60) begin @(negedge clk); g++; end
    t2 = cyc;
    chk("b2b_done_spacing", t2 - t1, 18);

    // Asynchronous reset mid-operation aborts without a done.
    @(negedge clk);
    dividend = 16'sd85;
    divisor  = -8'sd17;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_quotient", {16'b0, quotient}, 0);
    chk("abort_remainder", {24'b0, remainder}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    do_op(16'sd85, -8'sd17, -16'sd5, 8'sd0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("pending_expectations", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1);
  end

endmodule
